// File: rtl/flappy_engine.sv
// Flappy-bird game core: FSM, bird physics, obstacle spawn/scroll, scoring, collision and high score.
// Every register moves one step per clk with i_tick=1; all outputs are registered and there is no backpressure.
module flappy_engine #(
    parameter int NUM_OBS      = 3,
    parameter int BIRD_COL     = 250,
    parameter int SPAWN_COL    = 610,
    parameter int SPAWN_PERIOD = 120,
    parameter int SET2_TICKS   = 63,
    parameter int SCORE_W      = 6,
    parameter int SPEED_STEP   = 8,
    parameter int SPEED_MAX    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    input  logic                  i_flap,
    input  logic                  i_start,
    input  logic                  i_pause,
    input  logic                  i_resume,
    input  logic                  i_quit,
    input  logic [2:0]            i_choice,
    input  logic [8:0]            i_rand_row,
    output logic [2:0]            o_state,
    output logic [8:0]            o_bird_row,
    output logic [1:0]            o_bird_angle,
    output logic [7:0]            o_gap_height,
    output logic [9*NUM_OBS-1:0]  o_obs_row,
    output logic [10*NUM_OBS-1:0] o_obs_col,
    output logic [NUM_OBS-1:0]    o_obs_valid,
    output logic [SCORE_W-1:0]    o_score,
    output logic [SCORE_W-1:0]    o_hi_score,
    output logic                  o_collide
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_SET2  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;
    localparam logic [2:0] S_FAIL2 = 3'd6;

    localparam int SET2_W = (SET2_TICKS < 1) ? 1 : $clog2(SET2_TICKS + 1);
    localparam int SPN_W  = (SPAWN_PERIOD < 2) ? 1 : $clog2(SPAWN_PERIOD);
    localparam logic [9:0] THR_COL = 10'(BIRD_COL - 40);
    localparam logic [9:0] WIN_HI  = 10'(BIRD_COL + 40);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [2:0]         r_state;
    logic [8:0]         r_bird_row;
    logic [1:0]         r_bird_angle;
    logic [7:0]         r_gap;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_hi;
    logic               r_collide;
    logic [3:0]         r_rise;
    logic [6:0]         r_fall;
    logic [SET2_W-1:0]  r_set2_cnt;
    logic [SPN_W-1:0]   r_spawn_cnt;
    logic [9:0]         r_obs_col [NUM_OBS];
    logic [8:0]         r_obs_row [NUM_OBS];
    logic [NUM_OBS-1:0] r_obs_vld;

    logic [2:0]         w_state_nxt;
    logic               w_play_step;
    logic               w_lose;
    logic [3:0]         w_rise;
    logic [6:0]         w_fall;
    logic [8:0]         w_row;
    logic [1:0]         w_angle;
    logic [SPN_W-1:0]   w_spawn_nxt;
    logic [9:0]         w_sp_col [NUM_OBS];
    logic [8:0]         w_sp_row [NUM_OBS];
    logic [NUM_OBS-1:0] w_sp_vld;
    logic [9:0]         w_mv_col [NUM_OBS];
    logic [NUM_OBS-1:0] w_mv_vld;
    logic [9:0]         w_speed;
    logic [SCORE_W-1:0] w_score;
    logic               w_collide;
    logic [8:0]         w_fail2_row;

    assign w_fail2_row = r_bird_row + 9'd4;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else if (i_tick) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_SET;
            S_SET:   if (|i_choice) w_state_nxt = S_SET2;
            S_SET2:  if (r_set2_cnt == '0) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (i_pause) w_state_nxt = S_PAUSE;
                else if (r_collide) w_state_nxt = S_FAIL2;
            end
            S_PAUSE: if (i_resume) w_state_nxt = S_PLAY;
            S_FAIL2: if (w_fail2_row > 9'd440) w_state_nxt = S_FAIL;
            S_FAIL:  if (i_quit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The game only advances on PLAY ticks that neither pause nor end the game.
    always_comb begin
        o_state     = r_state;
        w_play_step = (r_state == S_PLAY) && !i_pause && !r_collide;
        w_lose      = (r_state == S_PLAY) && !i_pause && r_collide;
    end

    always_comb begin
        int v_speed;
        int v_sum;
        logic signed [10:0] v_lo;
        logic signed [10:0] v_hi;
        logic signed [10:0] v_bird;
        v_speed = 0;
        v_sum   = 0;
        v_lo    = '0;
        v_hi    = '0;
        v_bird  = '0;

        w_rise = r_rise;
        w_fall = r_fall;
        if (i_flap) begin
            w_rise = 4'd11;
            w_fall = 7'd0;
        end else if (r_rise != 4'd0) begin
            w_rise = r_rise - 4'd1;
        end else if (r_fall != 7'd127) begin
            w_fall = r_fall + 7'd1;
        end

        if (w_rise > 4'd8 && r_bird_row > 9'd19) begin
            w_row = r_bird_row - 9'd5;  w_angle = 2'd1;
        end else if (w_rise > 4'd3 && r_bird_row > 9'd19) begin
            w_row = r_bird_row - 9'd4;  w_angle = 2'd1;
        end else if (w_rise > 4'd0 && r_bird_row > 9'd19) begin
            w_row = r_bird_row - 9'd2;  w_angle = 2'd0;
        end else if (w_rise > 4'd0) begin
            w_row = 9'd19;              w_angle = 2'd0;
        end else if (r_bird_row < 9'd458) begin
            w_row = r_bird_row + {6'd0, w_fall[6:4]};  w_angle = 2'd2;
        end else begin
            w_row = 9'd465;             w_angle = 2'd0;
        end

        for (int i = 0; i < NUM_OBS; i++) begin
            w_sp_col[i] = r_obs_col[i];
            w_sp_row[i] = r_obs_row[i];
        end
        w_sp_vld    = r_obs_vld;
        w_spawn_nxt = r_spawn_cnt - SPN_W'(1);
        if (r_spawn_cnt == '0) begin
            for (int i = 1; i < NUM_OBS; i++) begin
                w_sp_col[i] = r_obs_col[i-1];
                w_sp_row[i] = r_obs_row[i-1];
                w_sp_vld[i] = r_obs_vld[i-1];
            end
            w_sp_col[0] = 10'(SPAWN_COL);
            w_sp_row[0] = i_rand_row;
            w_sp_vld[0] = 1'b1;
            w_spawn_nxt = SPN_W'(SPAWN_PERIOD - 1);
        end

        v_speed = 2 + int'(r_score) / SPEED_STEP;
        if (v_speed > SPEED_MAX) v_speed = SPEED_MAX;
        w_speed = 10'(v_speed);

        for (int i = 0; i < NUM_OBS; i++) begin
            if (w_sp_vld[i] && w_sp_col[i] >= 10'd25 + w_speed) begin
                w_mv_col[i] = w_sp_col[i] - w_speed;
                w_mv_vld[i] = 1'b1;
            end else begin
                w_mv_col[i] = '0;
                w_mv_vld[i] = 1'b0;
            end
            if (w_mv_vld[i] && w_sp_col[i] > THR_COL && w_mv_col[i] <= THR_COL) v_sum++;
        end
        v_sum   = v_sum + int'(r_score);
        w_score = (v_sum > int'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(v_sum);

        // Signed 11-bit bounds so a gap near the top edge cannot wrap.
        w_collide = 1'b0;
        v_bird    = $signed({2'b00, w_row});
        for (int i = 0; i < NUM_OBS; i++) begin
            v_lo = $signed({2'b00, w_sp_row[i]}) - $signed({4'b0000, r_gap[7:1]}) + 11'sd12;
            v_hi = $signed({2'b00, w_sp_row[i]}) + $signed({4'b0000, r_gap[7:1]}) - 11'sd12;
            if (w_mv_vld[i] && w_mv_col[i] > THR_COL && w_mv_col[i] < WIN_HI &&
                !(v_bird > v_lo && v_bird < v_hi)) begin
                w_collide = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bird_row   <= 9'd240;
            r_bird_angle <= 2'd0;
            r_gap        <= 8'd0;
            r_score      <= '0;
            r_hi         <= '0;
            r_collide    <= 1'b0;
            r_rise       <= 4'd0;
            r_fall       <= 7'd0;
            r_set2_cnt   <= '0;
            r_spawn_cnt  <= '0;
            r_obs_vld    <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_obs_col[i] <= '0;
                r_obs_row[i] <= '0;
            end
        end else if (i_tick) begin
            case (r_state)
                S_SET: begin
                    if (i_choice[2])      r_gap <= 8'd180;
                    else if (i_choice[1]) r_gap <= 8'd140;
                    else if (i_choice[0]) r_gap <= 8'd100;
                    else                  r_gap <= 8'd0;
                    if (|i_choice) r_set2_cnt <= SET2_W'(SET2_TICKS);
                end
                S_SET2: begin
                    if (r_set2_cnt == '0) begin
                        r_score      <= '0;
                        r_collide    <= 1'b0;
                        r_obs_vld    <= '0;
                        r_bird_row   <= 9'd240;
                        r_bird_angle <= 2'd0;
                        r_rise       <= 4'd0;
                        r_fall       <= 7'd0;
                        r_spawn_cnt  <= SPN_W'(SPAWN_PERIOD - 1);
                    end else begin
                        r_set2_cnt <= r_set2_cnt - SET2_W'(1);
                    end
                end
                S_PLAY: begin
                    if (w_play_step) begin
                        r_rise       <= w_rise;
                        r_fall       <= w_fall;
                        r_bird_row   <= w_row;
                        r_bird_angle <= w_angle;
                        r_spawn_cnt  <= w_spawn_nxt;
                        r_obs_vld    <= w_mv_vld;
                        r_score      <= w_score;
                        r_collide    <= w_collide;
                        for (int i = 0; i < NUM_OBS; i++) begin
                            r_obs_col[i] <= w_mv_col[i];
                            r_obs_row[i] <= w_sp_row[i];
                        end
                    end else if (w_lose && r_score > r_hi) begin
                        r_hi <= r_score;
                    end
                end
                S_FAIL2: r_bird_row <= w_fail2_row;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_bird_row   = r_bird_row;
        o_bird_angle = r_bird_angle;
        o_gap_height = r_gap;
        o_score      = r_score;
        o_hi_score   = r_hi;
        o_collide    = r_collide;
        o_obs_valid  = r_obs_vld;
        o_obs_row    = '0;
        o_obs_col    = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            o_obs_row[i*9 +: 9]   = r_obs_row[i];
            o_obs_col[i*10 +: 10] = r_obs_col[i];
        end
    end

endmodule
